set_pattern_driver: RTL

//  Initiator side of the SET circle-candidate interface: sequences NUM_PAT stored patterns into a SET

---
 rtl/set_pkg.sv | 26 ++
 rtl/set_watchdog.sv | 40 ++++
 rtl/set_pattern_driver.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/set_pkg.sv
// set_pkg: shared definitions for the SET pattern driver.
//   - FSM state encoding (kept as plain logic constants)
//   - SET mode encodings as carried on dut_mode
//   - data-path field widths of the SET circle-candidate interface
package set_pkg;

    localparam int CENTRAL_W = 24;  // {x1,y1,x2,y2,x3,y3}, 4b each
    localparam int RADIUS_W  = 12;  // {r1,r2,r3}
    localparam int CAND_W    = 8;   // candidate count / expected value
    localparam int MODE_W    = 2;

    localparam logic [MODE_W-1:0] MODE_SINGLE    = 2'b00;
    localparam logic [MODE_W-1:0] MODE_UNION     = 2'b01;
    localparam logic [MODE_W-1:0] MODE_DIFF      = 2'b10;
    localparam logic [MODE_W-1:0] MODE_INTERSECT = 2'b11;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_LOAD       = 3'd2;
    localparam logic [2:0] S_WAIT_IDLE  = 3'd3;
    localparam logic [2:0] S_ISSUE      = 3'd4;
    localparam logic [2:0] S_WAIT_VALID = 3'd5;
    localparam logic [2:0] S_CHECK      = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

endpackage

// File: rtl/set_watchdog.sv
// set_watchdog: per-wait cycle counter for the pattern driver.
//   clk_i      clock, rising edge
//   rst_i      synchronous reset, active-high
//   clr_i      restart the count at zero (wins over en_i)
//   en_i       count this cycle
//   expired_o  high while the count sits at TIMEOUT-1, i.e. during the
//              TIMEOUT-th enabled cycle since the last clear
module set_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

    // Saturate at the expire value so a caller that ignores expiry never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/set_pattern_driver.sv
// set_pattern_driver: on-chip self-test initiator for a SET core.
// Walks NUM_PAT ROM patterns, loads each into the SET engine, waits for the
// candidate and compares it with the expected count.
//   clk_i / rst_i          clock, synchronous active-high reset
//   start_i, mode_sel_i    run request (IDLE/DONE only) and mode latched with it
//   pat_addr_o             ROM address; pat_*_i data returns one cycle later
//   dut_en_o               one-cycle load strobe to SET
//   dut_central_o/radius_o pattern held from ISSUE until the next LOAD
//   dut_mode_o             mode for the whole run
//   dut_busy_i/valid_i/candidate_i  SET handshake and result
//   running_o, done_o, pass_o       run status
//   err_cnt_o, fail_idx_o, timeout_o  error count, first failing index, watchdog
module set_pattern_driver
    import set_pkg::*;
#(
    parameter int NUM_PAT = 64,
    parameter int ADDR_W  = 6,
    parameter int MAX_ERR = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [MODE_W-1:0]    mode_sel_i,
    output logic [ADDR_W-1:0]    pat_addr_o,
    input  logic [CENTRAL_W-1:0] pat_central_i,
    input  logic [RADIUS_W-1:0]  pat_radius_i,
    input  logic [CAND_W-1:0]    pat_expected_i,
    output logic                 dut_en_o,
    output logic [CENTRAL_W-1:0] dut_central_o,
    output logic [RADIUS_W-1:0]  dut_radius_o,
    output logic [MODE_W-1:0]    dut_mode_o,
    input  logic                 dut_busy_i,
    input  logic                 dut_valid_i,
    input  logic [CAND_W-1:0]    dut_candidate_i,
    output logic                 running_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [7:0]           err_cnt_o,
    output logic [ADDR_W-1:0]    fail_idx_o,
    output logic                 timeout_o
);

    localparam logic [7:0]        ERR_LIMIT = 8'(MAX_ERR);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PAT - 1);

    logic [2:0]           state_q,   state_d;
    logic [ADDR_W-1:0]    idx_q,     idx_d;
    logic [CENTRAL_W-1:0] central_q, central_d;
    logic [RADIUS_W-1:0]  radius_q,  radius_d;
    logic [CAND_W-1:0]    exp_q,     exp_d;
    logic [CAND_W-1:0]    cand_q,    cand_d;
    logic [MODE_W-1:0]    mode_q,    mode_d;
    logic [7:0]           err_q,     err_d;
    logic [ADDR_W-1:0]    fail_q,    fail_d;
    logic                 tmo_q,     tmo_d;

    logic wd_clr, wd_en, wd_expired;

    // Watchdog restarts on entry to each wait state (LOAD precedes WAIT_IDLE,
    // ISSUE precedes WAIT_VALID) so each wait gets its own TIMEOUT budget.
    assign wd_clr = (state_q == S_LOAD) || (state_q == S_ISSUE);
    assign wd_en  = (state_q == S_WAIT_IDLE) || (state_q == S_WAIT_VALID);

    set_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        central_d = central_q;
        radius_d  = radius_q;
        exp_d     = exp_q;
        cand_d    = cand_q;
        mode_d    = mode_q;
        err_d     = err_q;
        fail_d    = fail_q;
        tmo_d     = tmo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    idx_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    tmo_d   = 1'b0;
                    mode_d  = mode_sel_i;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;   // pat_addr_o = idx_q this cycle
            S_LOAD: begin
                central_d = pat_central_i;
                radius_d  = pat_radius_i;
                exp_d     = pat_expected_i;
                state_d   = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                // Idle SET takes priority over a watchdog expiring the same cycle.
                if (!dut_busy_i) begin
                    state_d = S_ISSUE;
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_ISSUE: state_d = S_WAIT_VALID;
            S_WAIT_VALID: begin
                if (dut_valid_i) begin
                    cand_d  = dut_candidate_i;
                    state_d = S_CHECK;
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_CHECK: begin
                if (cand_q != exp_q) begin
                    err_d = err_q + 8'd1;
                    if (err_q == 8'd0)
                        fail_d = idx_q;
                end
                if (err_d == ERR_LIMIT)
                    state_d = S_DONE;
                else if (idx_q == LAST_IDX)
                    state_d = S_DONE;
                else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            central_q <= '0;
            radius_q  <= '0;
            exp_q     <= '0;
            cand_q    <= '0;
            mode_q    <= MODE_SINGLE;
            err_q     <= '0;
            fail_q    <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            central_q <= central_d;
            radius_q  <= radius_d;
            exp_q     <= exp_d;
            cand_q    <= cand_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
        end
    end

    // Strobe and status decode straight from the state register, so all of
    // them drop at the same edge that samples rst_i.
    assign pat_addr_o    = idx_q;
    assign dut_en_o      = (state_q == S_ISSUE);
    assign dut_central_o = central_q;
    assign dut_radius_o  = radius_q;
    assign dut_mode_o    = mode_q;
    assign running_o     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = (state_q == S_DONE);
    assign pass_o        = done_o && (err_q == 8'd0) && !tmo_q;
    assign err_cnt_o     = err_q;
    assign fail_idx_o    = fail_q;
    assign timeout_o     = tmo_q;

endmodule
